uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLK_HZ, 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter: BAUD, 9600, line bit rate.
REQ-003 SHALL derive localparam DIV = CLK_HZ/(BAUD*16) with integer floor; default value 651.
REQ-004 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: i_rxd  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-007 SHALL have port: o_data  output  8  last correctly framed byte.
REQ-008 SHALL have port: o_valid  output  1  one-cycle pulse when o_data is updated.
REQ-009 SHALL have port: o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port: o_busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass i_rxd through a 2-flop synchronizer; all decisions use the second flop (rxd_s).
REQ-012 SHALL generate a 1-cycle oversample tick every DIV clocks from a free-running counter 0..DIV-1 that wraps to 0.
REQ-013 SHALL keep a 4-bit tick count (0..15) and a 3-bit bit index; both SHALL clear on every state transition.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: rxd_s==0 -> START. Otherwise stay.
REQ-016 START: on the tick that makes the tick count reach 7 (mid start bit), rxd_s==0 -> DATA; rxd_s==1 -> IDLE. This rejects glitches shorter than half a bit, with no output pulse.
REQ-017 DATA: on each 16th tick, sample rxd_s into shift[bit index], then increment the bit index.
REQ-018 DATA: after bit index 7 is sampled, go to STOP.
REQ-019 STOP: on the 16th tick, rxd_s==1 -> load o_data from shift, pulse o_valid, go to IDLE.
REQ-020 STOP: on the 16th tick, rxd_s==0 -> pulse o_frame_err, leave o_data unchanged, go to BREAK.
REQ-021 BREAK: rxd_s==1 -> IDLE. A held-low line SHALL NOT produce repeated frames.
REQ-022 o_valid and o_frame_err SHALL be registered, SHALL assert the clock after the deciding tick, and SHALL last exactly 1 cycle; they SHALL never be high together.
REQ-023 o_data SHALL hold its value between frames and change only together with o_valid.
REQ-024 A start edge arriving in the same cycle as the return to IDLE SHALL be detected on the next cycle; no frame is lost at back-to-back frames with 1 stop bit.
REQ-025 i_rxd changes during DATA or STOP outside the sample ticks SHALL have no effect.

Reset
REQ-026 On reset: state=IDLE, both synchronizer flops=1, tick/divider/bit counters=0, shift=0, o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no o_valid or o_frame_err pulse; reception restarts at the next falling edge after reset is released.

Verification (bench uses CLK_HZ=64*BAUD, so DIV=4 and 1 bit = 64 clocks)
REQ-028 Frame 0x55 with a good stop bit -> one o_valid pulse, o_data=8'h55, o_frame_err=0, o_busy low after the pulse.
REQ-029 Frames 0xA3, 0x00, 0xFF back-to-back with 1 stop bit -> three o_valid pulses with o_data 8'hA3, 8'h00, 8'hFF in order.
REQ-030 Low glitch of 20 clocks on an idle line -> return to IDLE, no o_valid, no o_frame_err.
REQ-031 Frame 0x3C with the stop bit driven low, then the line held low for 5 bit times, then high -> exactly one o_frame_err pulse, o_data keeps its previous value, no further pulses.
REQ-032 Reset pulsed during data bit 4 of frame 0x81, then a clean frame 0x42 -> no pulse for 0x81, then o_valid with o_data=8'h42.
REQ-033 Sender baud error of +/-3% on frame 0xC9 -> o_valid with o_data=8'hC9.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, glitch rejection on the
// start bit and a BREAK state that swallows a held-low line after a framing error.
module uart_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rxd_meta;
    logic             rxd_s;
    logic [1:0]       sync_fill;
    logic             armed;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             sample_bit;
    logic             frame_ok;
    logic             frame_bad;

    // Synchronizer. The reset value of the flops is not a real line level, so a
    // start is only accepted once the line itself has been seen high after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta  <= 1'b1;
            rxd_s     <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rxd_meta  <= i_rxd;
            rxd_s     <= rxd_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rxd_s)
                armed <= 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        sample_bit = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rxd_s)
                    state_nxt = START;
            end
            START: begin
                if (tick && tick_cnt == 4'd6)
                    state_nxt = rxd_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick && tick_cnt == 4'd15) begin
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7)
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick && tick_cnt == 4'd15) begin
                    if (rxd_s) begin
                        frame_ok  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tick and bit counters restart on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            if (state_nxt != state) begin
                tick_cnt <= '0;
                bit_idx  <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                if (sample_bit)
                    bit_idx <= bit_idx + 3'd1;
            end
            if (sample_bit)
                shift[bit_idx] <= rxd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= frame_ok;
            o_frame_err <= frame_bad;
            if (frame_ok)
                o_data <= shift;
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLK_HZ = 64*BAUD (4 clocks per oversample tick, 64 per bit).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BAUD   = 9600;
    localparam int CLK_HZ = 64 * BAUD;
    localparam int BIT_NS = 640;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    int tests_run = 0;
    int failed = 0;

    logic [8:0] ev_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] exp_data;
    logic [7:0] prev_data = 8'h00;
    int         n_both = 0;
    int         n_busy_at_valid = 0;
    int         n_data_glitch = 0;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_rxd      (rxd),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Event recorder: every output pulse becomes one entry {err, data}.
    always @(negedge clk) begin
        if (o_valid)     ev_q.push_back({1'b0, o_data});
        if (o_frame_err) ev_q.push_back(9'h100);
        if (o_valid && o_frame_err) n_both++;
        if (o_valid && o_busy) n_busy_at_valid++;
        if (!reset && o_data !== prev_data && !o_valid) n_data_glitch++;
        prev_data = o_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a frame with a high stop bit delivers its byte, otherwise a framing error.
    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (stop) begin
            exp_q.push_back({1'b0, d});
            exp_data = d;
        end else begin
            exp_q.push_back(9'h100);
        end
    endtask

    task automatic align();
        @(negedge clk);
        #($urandom_range(1, 4));
    endtask

    // Drives start, 8 data bits LSB first and the stop bit. rst_bit selects a frame bit
    // (0 = start) during which reset is pulsed; glitch adds a short inverted blip at the
    // start of every data/stop bit, far from the mid-bit sample point.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ns,
                              input int rst_bit, input bit glitch);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == rst_bit) begin
                rxd = bits[i];
                #(bit_ns / 2);
                reset = 1'b1;
                #40;
                reset = 1'b0;
                #(bit_ns - bit_ns / 2 - 40);
            end else if (glitch && i > 0) begin
                rxd = ~bits[i];
                #30;
                rxd = bits[i];
                #(bit_ns - 30);
            end else begin
                rxd = bits[i];
                #(bit_ns);
            end
        end
    endtask

    task automatic settle();
        rxd = 1'b1;
        repeat (120) @(posedge clk);
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, " event count"}, ev_q.size(), exp_q.size());
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s event %0d", tag, i), ev_q[i], exp_q[i]);
        @(negedge clk);
        check({tag, " o_data held"}, o_data, exp_data);
        check({tag, " o_busy idle"}, o_busy, 1'b0);
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        int         bit_ns;

        exp_data = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset o_data", o_data, 8'h00);
        check("reset o_valid", o_valid, 1'b0);
        check("reset o_frame_err", o_frame_err, 1'b0);
        check("reset o_busy", o_busy, 1'b0);
        reset = 1'b0;
        repeat (20) @(posedge clk);

        // Single good frame.
        align();
        send_frame(8'h55, 1'b1, BIT_NS, -1, 1'b0);
        model_frame(8'h55, 1'b1);
        settle();
        compare("frame55");

        // Back-to-back frames, one stop bit each.
        align();
        send_frame(8'hA3, 1'b1, BIT_NS, -1, 1'b0);
        send_frame(8'h00, 1'b1, BIT_NS, -1, 1'b0);
        send_frame(8'hFF, 1'b1, BIT_NS, -1, 1'b0);
        model_frame(8'hA3, 1'b1);
        model_frame(8'h00, 1'b1);
        model_frame(8'hFF, 1'b1);
        settle();
        compare("b2b");

        // Short low glitch on an idle line.
        align();
        rxd = 1'b0;
        repeat (20) @(posedge clk);
        settle();
        compare("glitch");

        // Bad stop bit followed by a held-low line.
        align();
        send_frame(8'h3C, 1'b0, BIT_NS, -1, 1'b0);
        model_frame(8'h3C, 1'b0);
        #(5 * BIT_NS);
        settle();
        compare("break");

        // Reset during data bit 4 (frame bit 5) of 0x81, then a clean 0x42.
        align();
        send_frame(8'h81, 1'b1, BIT_NS, 5, 1'b0);
        exp_data = 8'h00;
        settle();
        align();
        send_frame(8'h42, 1'b1, BIT_NS, -1, 1'b0);
        model_frame(8'h42, 1'b1);
        settle();
        compare("reset_abort");

        // Sender clock about 3% fast and 3% slow.
        align();
        send_frame(8'hC9, 1'b1, 621, -1, 1'b0);
        model_frame(8'hC9, 1'b1);
        settle();
        align();
        send_frame(8'hC9, 1'b1, 659, -1, 1'b0);
        model_frame(8'hC9, 1'b1);
        settle();
        compare("baud_err");

        // Line activity away from the sample points.
        align();
        send_frame(8'h96, 1'b1, BIT_NS, -1, 1'b1);
        model_frame(8'h96, 1'b1);
        settle();
        compare("midbit_noise");

        // Randomized frames: random byte, mostly good stop bits, baud within +/-2%.
        for (int k = 0; k < 8; k++) begin
            d      = 8'($urandom_range(0, 255));
            stop   = ($urandom_range(0, 3) != 0);
            bit_ns = $urandom_range(627, 653);
            align();
            send_frame(d, stop, bit_ns, -1, 1'b0);
            model_frame(d, stop);
            if (!stop) #(BIT_NS);
            settle();
        end
        compare("random");

        check("valid and frame_err together", n_both, 0);
        check("busy high at valid", n_busy_at_valid, 0);
        check("o_data changed without valid", n_data_glitch, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
